// File: rtl/matched_filter_stream.sv
// Streaming complex matched filter: one time-multiplexed complex MAC walks a
// runtime-loaded template against the sample history, valid/ready on input.
module matched_filter_stream #(
  parameter int  DATA_WIDTH  = 18,
  parameter int  COEFF_WIDTH = 18,
  parameter int  TAP_COUNT   = 16,
  localparam int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAP_COUNT) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          conjMode,
  input  logic                          coeffLoad,
  input  logic signed [COEFF_WIDTH-1:0] coeffInRe,
  input  logic signed [COEFF_WIDTH-1:0] coeffInIm,
  output logic                          coeffsValid,
  input  logic                          dataInValid,
  input  logic signed [DATA_WIDTH-1:0]  dataInRe,
  input  logic signed [DATA_WIDTH-1:0]  dataInIm,
  output logic                          dataInReady,
  output logic                          MFOutputValid,
  output logic signed [ACC_WIDTH-1:0]   MFOutputRe,
  output logic signed [ACC_WIDTH-1:0]   MFOutputIm
);
  localparam int AW  = $clog2(TAP_COUNT);
  localparam int PW  = DATA_WIDTH + COEFF_WIDTH;
  localparam int EXT = ACC_WIDTH - PW;
  localparam logic [AW-1:0] LAST  = AW'(TAP_COUNT - 1);
  localparam logic [AW-1:0] NWRAP = AW'(TAP_COUNT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] coeffAddr, wrPtr, tap;
  logic          conjLat;
  logic [TAP_COUNT-1:0][COEFF_WIDTH-1:0] hRe, hIm;
  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0]  xRe, xIm;
  logic signed [ACC_WIDTH-1:0] accRe, accIm;

  assign dataInReady = (state == S_IDLE) & coeffsValid & enable;

  // History read index (wrPtr - tap) mod N; the borrow bit selects the wrap.
  logic [AW:0]   diff;
  logic [AW-1:0] rdIdx;
  assign diff  = {1'b0, wrPtr} - {1'b0, tap};
  assign rdIdx = diff[AW] ? diff[AW-1:0] + NWRAP : diff[AW-1:0];

  logic signed [PW-1:0] xr, xi, hr, hi;
  assign xr = {{COEFF_WIDTH{xRe[rdIdx][DATA_WIDTH-1]}}, xRe[rdIdx]};
  assign xi = {{COEFF_WIDTH{xIm[rdIdx][DATA_WIDTH-1]}}, xIm[rdIdx]};
  assign hr = {{DATA_WIDTH{hRe[tap][COEFF_WIDTH-1]}}, hRe[tap]};
  assign hi = {{DATA_WIDTH{hIm[tap][COEFF_WIDTH-1]}}, hIm[tap]};

  logic signed [PW-1:0] pRR, pII, pRI, pIR;
  assign pRR = xr * hr;
  assign pII = xi * hi;
  assign pRI = xr * hi;
  assign pIR = xi * hr;

  logic signed [ACC_WIDTH-1:0] eRR, eII, eRI, eIR, dRe, dIm;
  assign eRR = {{EXT{pRR[PW-1]}}, pRR};
  assign eII = {{EXT{pII[PW-1]}}, pII};
  assign eRI = {{EXT{pRI[PW-1]}}, pRI};
  assign eIR = {{EXT{pIR[PW-1]}}, pIR};
  assign dRe = conjLat ? eRR + eII : eRR - eII;
  assign dIm = conjLat ? eIR - eRI : eRI + eIR;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      coeffAddr     <= '0;
      wrPtr         <= '0;
      tap           <= '0;
      conjLat       <= 1'b0;
      hRe           <= '0;
      hIm           <= '0;
      xRe           <= '0;
      xIm           <= '0;
      accRe         <= '0;
      accIm         <= '0;
      coeffsValid   <= 1'b0;
      MFOutputValid <= 1'b0;
      MFOutputRe    <= '0;
      MFOutputIm    <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          MFOutputValid <= 1'b0;
          // A coefficient write takes priority over a pending sample.
          if (coeffLoad) begin
            hRe[coeffAddr] <= coeffInRe;
            hIm[coeffAddr] <= coeffInIm;
            if (coeffAddr == LAST) begin
              coeffAddr   <= '0;
              coeffsValid <= 1'b1;
            end else begin
              coeffAddr <= coeffAddr + 1'b1;
              if (coeffAddr == '0) coeffsValid <= 1'b0;
            end
          end else if (dataInValid && coeffsValid) begin
            xRe[wrPtr] <= dataInRe;
            xIm[wrPtr] <= dataInIm;
            accRe      <= '0;
            accIm      <= '0;
            tap        <= '0;
            conjLat    <= conjMode;
            state      <= S_MAC;
          end
        end
        S_MAC: begin
          accRe <= accRe + dRe;
          accIm <= accIm + dIm;
          if (tap == LAST) begin
            state <= S_OUT;
            wrPtr <= (wrPtr == LAST) ? '0 : wrPtr + 1'b1;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_OUT: begin
          MFOutputRe    <= accRe;
          MFOutputIm    <= accIm;
          MFOutputValid <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/matched_filter_stream.md
Name: matched_filter_stream

Overview:
- Streaming complex matched filter with a runtime-loadable template: y[n] = sum over k of x[n-k]·h[k], or ·conj(h[k]) in conjugate mode.
- Time-multiplexes one complex MAC over TAP_COUNT taps and exchanges samples via valid/ready handshakes.
- Parametrised successor of the fixed-template matched_filter. It adds a coefficient load port, a conjugate mode, handshaking, and full-precision output.
- Sits between the ADC/IQ front end and the peak detector.

Parameters:
- DATA_WIDTH, 18, signed width of dataInRe/dataInIm.
- COEFF_WIDTH, 18, signed width of coeffInRe/coeffInIm.
- TAP_COUNT, 16, template length N; must be ≥2.
- ACC_WIDTH (localparam), DATA_WIDTH+COEFF_WIDTH+$clog2(TAP_COUNT)+1, output width.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when low, all state, counters and pointers hold; outputs hold.
- conjMode  input  1  1 = multiply by conj(h); sampled at sample acceptance.
- coeffLoad  input  1  write strobe for one coefficient.
- coeffInRe  input  COEFF_WIDTH  template real part.
- coeffInIm  input  COEFF_WIDTH  template imaginary part.
- coeffsValid  output  1  full template loaded.
- dataInValid  input  1  sample present.
- dataInRe  input  DATA_WIDTH  sample real part.
- dataInIm  input  DATA_WIDTH  sample imaginary part.
- dataInReady  output  1  block can accept a sample.
- MFOutputValid  output  1  one-cycle strobe marking a new result.
- MFOutputRe  output  ACC_WIDTH  signed result, real part.
- MFOutputIm  output  ACC_WIDTH  signed result, imaginary part.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; coefficient RAM, sample history, accumulators, pointers = 0.
  - coeffsValid=0, dataInReady=0, MFOutputValid=0, MFOutputRe/Im=0.
- State machine:
  - IDLE → MAC → OUTPUT → IDLE; transitions only while enable=1.
  - dataInReady = (state==IDLE) & coeffsValid & enable (combinational from registers).
- Coefficient load:
  - Accepted only in IDLE with enable=1. Each coeffLoad cycle writes h[coeffAddr]; coeffAddr increments.
  - The write with coeffAddr=0 clears coeffsValid.
  - The write with coeffAddr=N-1 wraps coeffAddr to 0 and sets coeffsValid=1.
  - coeffLoad in MAC/OUTPUT is ignored and coeffAddr is unchanged.
  - If coeffLoad and dataInValid are both high in IDLE, the load wins and no sample is accepted.
- Sample acceptance (edge where dataInValid & dataInReady):
  - Write sample to history[wrPtr].
  - Clear accumulators, set k=0, latch conjMode, go to MAC.
  - wrPtr increments modulo N after the MAC phase completes.
  - History starts at zero, so the first N-1 outputs include zero-padded history.
- MAC: one tap per enabled cycle, N cycles.
  - Operands: xk = history[(wrPtr-k) mod N], hk = h[k].
  - Normal: accRe += xr·hr − xi·hi; accIm += xr·hi + xi·hr.
  - Conj: accRe += xr·hr + xi·hi; accIm += xi·hr − xr·hi.
  - Arithmetic is all signed, sign-extended to ACC_WIDTH, with no rounding or saturation. ACC_WIDTH guarantees no overflow.
  - After tap N-1, go to OUTPUT.
- OUTPUT (one enabled cycle):
  - MFOutputRe/Im <= acc, MFOutputValid=1 for exactly that cycle, next state IDLE.
  - MFOutputRe/Im hold until the next OUTPUT.
- Timing:
  - Latency: sample accepted at edge E0 → MFOutputValid high in the cycle after edge E0+N+1, plus any cycles with enable=0.
  - Throughput: one sample per N+2 cycles; dataInReady is low in MAC/OUTPUT.
- enable=0 mid-MAC/OUTPUT: freeze. MFOutputValid stays at its current value, so a stretched strobe counts as one result.
- Reset mid-operation: immediate return to reset values. The template must be reloaded before dataInReady rises.
- No output is produced until coeffsValid=1.

Test Plan:
- Impulse, N=16: load h[k]=(k+1, 0); send x=(1,0) then 17 samples of (0,0) → 18 outputs. MFOutputRe is 1..16, then 0, then 0; MFOutputIm is 0 throughout.
- Conj mode: h all (0,1), x=(0,1) single sample, first output → conjMode=0 gives (−1,0); conjMode=1 gives (1,0).
- Full scale: h all (−131072, 0); 16 samples x=(−131072, 0) → 16th output MFOutputRe=274877906944 (2^38), MFOutputIm=0, no wrap.
- Handshake/latency and enable freeze:
  - Assert dataInValid continuously → dataInReady pulses once per 18 cycles and MFOutputValid lands 17 cycles after each accept.
  - Drop enable 5 cycles mid-MAC → same values, latency 22.
- Load arbitration: coeffLoad pulsed during MAC → h unchanged and results unchanged. coeffLoad and dataInValid together in IDLE → only the coefficient is written.
- Reset mid-MAC → all outputs 0, coeffsValid=0, dataInReady stays 0 until 16 fresh coeffLoad writes. The subsequent impulse test passes.
